mod_det_seq: RTL

MOD_DET_SEQ -- requirements
Module: mod_det_seq

---
 rtl/mod_det_seq.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mod_det_seq.sv
// mod_det_seq: sequential determinant unit for 3x3 or 2x2 signed matrices.
// A single shared multiplier is used once per compute cycle. Minors are
// built in two cycles and then folded into the accumulator by a cofactor cycle.
//
// Ports:
//   clk        - rising-edge clock
//   reset_n    - asynchronous active-low reset
//   start      - request pulse, accepted in IDLE or DONE
//   mode       - 0 = 3x3 determinant, 1 = 2x2 determinant ([a b; c d])
//   a .. i     - row-major matrix elements, WIDTH-bit two's complement
//   busy       - high while MINOR_P / MINOR_Q / COF are active
//   done       - one-cycle pulse, result valid in that cycle
//   resultado  - low WIDTH bits of the full-precision determinant
//   overflow   - determinant does not fit in signed WIDTH bits
module mod_det_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic [WIDTH-1:0] i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado,
  output logic             overflow
);

  localparam int AW = 3*WIDTH + 2;  // accumulator / minor width
  localparam int PW = 3*WIDTH + 1;  // full product width
  localparam int MW = 2*WIDTH + 1;  // minor operand width fed to the multiplier

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MINOR_P = 3'd1,
    MINOR_Q = 3'd2,
    COF     = 3'd3,
    DONE    = 3'd4
  } state_t;

  // 1 when the value lies outside the signed WIDTH-bit range, i.e. the bits
  // above the result sign bit are not all copies of it.
  function automatic logic out_of_range(input logic [AW-1:0] v);
    logic [AW-WIDTH:0] top;
    top = v[AW-1:WIDTH-1];
    if ((top == {(AW-WIDTH+1){1'b0}}) || (top == {(AW-WIDTH+1){1'b1}})) begin
      return 1'b0;
    end else begin
      return 1'b1;
    end
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       k_q, k_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] op_q [9];
  logic [WIDTH-1:0] op_d [9];
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    minor_q, minor_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] mul_a_s;
  logic [WIDTH-1:0] elem_b_s;
  logic             use_minor_s;
  logic [MW-1:0]    mul_b_s;
  logic [PW-1:0]    mul_a_ext_s;
  logic [PW-1:0]    mul_b_ext_s;
  logic [PW-1:0]    prod_s;
  logic [AW-1:0]    prod_ext_s;
  logic [AW-1:0]    final_s;
  logic             accept_s;

  // Multiplier operand selection; op index 0..8 = a..i.
  always_comb begin
    mul_a_s     = '0;
    elem_b_s    = '0;
    use_minor_s = 1'b0;
    case (state_q)
      MINOR_P: begin
        if (mode_q) begin
          mul_a_s = op_q[0]; elem_b_s = op_q[3];
        end else begin
          case (k_q)
            2'd0:    begin mul_a_s = op_q[4]; elem_b_s = op_q[8]; end
            2'd1:    begin mul_a_s = op_q[3]; elem_b_s = op_q[8]; end
            2'd2:    begin mul_a_s = op_q[3]; elem_b_s = op_q[7]; end
            default: begin mul_a_s = '0;      elem_b_s = '0;      end
          endcase
        end
      end
      MINOR_Q: begin
        if (mode_q) begin
          mul_a_s = op_q[1]; elem_b_s = op_q[2];
        end else begin
          case (k_q)
            2'd0:    begin mul_a_s = op_q[5]; elem_b_s = op_q[7]; end
            2'd1:    begin mul_a_s = op_q[5]; elem_b_s = op_q[6]; end
            2'd2:    begin mul_a_s = op_q[4]; elem_b_s = op_q[6]; end
            default: begin mul_a_s = '0;      elem_b_s = '0;      end
          endcase
        end
      end
      COF: begin
        use_minor_s = 1'b1;
        case (k_q)
          2'd0:    mul_a_s = op_q[0];
          2'd1:    mul_a_s = op_q[1];
          2'd2:    mul_a_s = op_q[2];
          default: mul_a_s = '0;
        endcase
      end
      default: begin
        mul_a_s = '0;
      end
    endcase
  end

  // Shared signed WIDTH x (2*WIDTH+1) multiplier; both sides sign-extended to
  // the product width so the low PW bits are the exact signed product.
  always_comb begin
    mul_b_s     = use_minor_s ? minor_q[MW-1:0]
                              : {{(WIDTH+1){elem_b_s[WIDTH-1]}}, elem_b_s};
    mul_a_ext_s = {{MW{mul_a_s[WIDTH-1]}}, mul_a_s};
    mul_b_ext_s = {{WIDTH{mul_b_s[MW-1]}}, mul_b_s};
    prod_s      = mul_a_ext_s * mul_b_ext_s;
    prod_ext_s  = {prod_s[PW-1], prod_s};
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    mode_d   = mode_q;
    op_d     = op_q;
    acc_d    = acc_q;
    minor_d  = minor_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    final_s  = acc_q;
    accept_s = start && ((state_q == IDLE) || (state_q == DONE));
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          op_d    = '{a, b, c, d, e, f, g, h, i};
          mode_d  = mode;
          acc_d   = '0;
          k_d     = 2'd0;
          state_d = MINOR_P;
        end else begin
          state_d = IDLE;
        end
      end
      MINOR_P: begin
        minor_d = prod_ext_s;
        state_d = MINOR_Q;
      end
      MINOR_Q: begin
        minor_d = minor_q - prod_ext_s;
        if (mode_q) begin
          // 2x2: the single minor is the determinant itself.
          final_s = minor_q - prod_ext_s;
          acc_d   = final_s;
          res_d   = final_s[WIDTH-1:0];
          ovf_d   = out_of_range(final_s);
          state_d = DONE;
        end else begin
          state_d = COF;
        end
      end
      COF: begin
        // Middle cofactor carries the negative sign.
        if (k_q == 2'd1) begin
          final_s = acc_q - prod_ext_s;
        end else begin
          final_s = acc_q + prod_ext_s;
        end
        acc_d = final_s;
        if (k_q == 2'd2) begin
          res_d   = final_s[WIDTH-1:0];
          ovf_d   = out_of_range(final_s);
          state_d = DONE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = MINOR_P;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == MINOR_P) || (state_d == MINOR_Q) || (state_d == COF);
    done_d = (state_d == DONE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      mode_q  <= 1'b0;
      for (int n = 0; n < 9; n++) begin
        op_q[n] <= '0;
      end
      acc_q   <= '0;
      minor_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      minor_q <= minor_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign resultado = res_q;
  assign overflow  = ovf_q;

endmodule
